// File: rtl/timer_scheduler_pkg.sv
// Shared types and sizing helpers for the shared countdown-timer scheduler.
package timer_scheduler_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned COUNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Pointer/index width; at least one bit so a 1-wide vector stays legal.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational rotate-priority pick: first set request at or after ptr_i, wrapping.
module timer_scheduler_rr_arbiter
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned N = N_REQ_DEF
) (
  input  logic [N-1:0]        req_i,
  input  logic [ptr_w(N)-1:0] ptr_i,
  output logic [N-1:0]        gnt_o,
  output logic [ptr_w(N)-1:0] idx_o,
  output logic                valid_o
);

  localparam int unsigned PTR_W = ptr_w(N);

  always_comb begin
    int unsigned cand;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = PTR_W'(cand);
      end
    end
    gnt_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/timer_scheduler.sv
// One programmable countdown timer shared round-robin among N_REQ requesters.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*COUNT_W-1:0]   count_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic [N_REQ-1:0]           done_o,
  output logic                       busy_o
);

  localparam int unsigned PTR_W = ptr_w(N_REQ);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   arb_gnt_c;
  logic [PTR_W-1:0]   arb_idx_c;
  logic               arb_valid_c;
  logic [COUNT_W-1:0] cnt_sel_c;

  timer_scheduler_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_c),
    .idx_o   (arb_idx_c),
    .valid_o (arb_valid_c)
  );

  assign cnt_sel_c = count_i[32'(arb_idx_c)*COUNT_W +: COUNT_W];

  // Next-state: IDLE arbitrates and loads max(C,1)-1; RUN aborts, expires or decrements.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          grant_d = arb_gnt_c;
          busy_d  = 1'b1;
          sel_d   = arb_idx_c;
          cnt_d   = (cnt_sel_c == '0) ? '0 : cnt_sel_c - COUNT_W'(1);
          ptr_d   = (arb_idx_c == PTR_W'(N_REQ-1)) ? '0 : arb_idx_c + PTR_W'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req_i[sel_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          grant_d       = '0;
          busy_d        = 1'b0;
          done_d[sel_q] = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q - COUNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule
